// File: rtl/instruction_sequencer_pkg.sv
// seq_pkg: state encoding shared by the instruction sequencer and its users.
package seq_pkg;
   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXECUTE = 3'd2,
      MEM     = 3'd3,
      HALT    = 3'd4
   } seq_state_e;
endpackage

// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if: instruction and data memory request/ready handshakes.
interface instruction_sequencer_if #(parameter int INST_W = 16);
   logic              imem_req;
   logic              imem_ready;
   logic [INST_W-1:0] imem_rdata;
   logic              dmem_req;
   logic              dmem_ready;
   modport master (output imem_req, dmem_req, input imem_ready, imem_rdata, dmem_ready);
   modport slave  (input imem_req, dmem_req, output imem_ready, imem_rdata, dmem_ready);
endinterface

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/decode/execute/mem control FSM with IR, commit strobes, halt/step and retire counter.
module instruction_sequencer
   import seq_pkg::*;
#(
   parameter int INST_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   instruction_sequencer_if.master mem,
   output logic [INST_W-1:0]       instruction,
   input  logic                    dec_acc_write_enable,
   input  logic                    dec_write_put_acc,
   input  logic                    dec_status_write_enable,
   input  logic                    dec_data_memory_write_enable,
   input  logic                    dec_data_memory_output_enable,
   output logic                    acc_write_strobe,
   output logic                    reg_write_strobe,
   output logic                    status_write_strobe,
   output logic                    dmem_write_strobe,
   output logic                    pc_update,
   output logic                    retire,
   input  logic                    halt_req,
   input  logic                    step,
   output logic                    halted,
   output logic [CNT_W-1:0]        retired_count
);
   seq_state_e state, nxt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= FETCH;
         instruction   <= '0;
         retired_count <= '0;
      end else begin
         state <= nxt;
         if (state == FETCH && mem.imem_ready) instruction <= mem.imem_rdata;
         if (retire) retired_count <= retired_count + CNT_W'(1);
      end
   // Outputs are gated by rst_n so nothing, not even imem_req, escapes while reset is held.
   always_comb begin
      nxt                 = state;
      mem.imem_req        = 1'b0;
      mem.dmem_req        = 1'b0;
      acc_write_strobe    = 1'b0;
      reg_write_strobe    = 1'b0;
      status_write_strobe = 1'b0;
      dmem_write_strobe   = 1'b0;
      pc_update           = 1'b0;
      retire              = 1'b0;
      halted              = 1'b0;
      if (rst_n)
         case (state)
            FETCH: begin
               mem.imem_req = 1'b1;
               nxt          = mem.imem_ready ? DECODE : FETCH;
            end
            DECODE:
               nxt = (dec_data_memory_write_enable || dec_data_memory_output_enable) ? MEM : EXECUTE;
            EXECUTE: begin
               acc_write_strobe    = dec_acc_write_enable;
               reg_write_strobe    = dec_write_put_acc;
               status_write_strobe = dec_status_write_enable;
               pc_update           = 1'b1;
               retire              = 1'b1;
               nxt                 = halt_req ? HALT : FETCH;
            end
            MEM: begin
               mem.dmem_req      = 1'b1;
               dmem_write_strobe = mem.dmem_ready && dec_data_memory_write_enable;
               acc_write_strobe  = mem.dmem_ready && dec_data_memory_output_enable;
               pc_update         = mem.dmem_ready;
               retire            = mem.dmem_ready;
               nxt               = !mem.dmem_ready ? MEM : halt_req ? HALT : FETCH;
            end
            HALT: begin
               halted = 1'b1;
               nxt    = (!halt_req || step) ? FETCH : HALT;
            end
            default: nxt = FETCH;
         endcase
   end
endmodule
